// File: rtl/rd_fwft_stage_if.sv
// Read-side bus of the FWFT stage: FIFO read port plus consumer valid/ready handshake.
// The master modport is the stage itself; the slave modport is its environment.
interface rd_fwft_stage_if #(
  parameter int DATASIZE = 8
);
  logic                fifo_empty_i;
  logic [DATASIZE-1:0] rdata_i;
  logic                ren_o;
  logic [DATASIZE-1:0] dout_o;
  logic                dout_valid_o;
  logic                dout_ready_i;
  logic [1:0]          occupancy_o;

  modport master (
    input  fifo_empty_i, rdata_i, dout_ready_i,
    output ren_o, dout_o, dout_valid_o, occupancy_o
  );

  modport slave (
    output fifo_empty_i, rdata_i, dout_ready_i,
    input  ren_o, dout_o, dout_valid_o, occupancy_o
  );
endinterface

// File: rtl/rd_fwft_stage.sv
// First-word-fall-through output stage with a 2-entry head/tail buffer on the FIFO read side.
// Optional synchronous flush_i port enabled by defining RD_FWFT_FLUSH_EN.
module rd_fwft_stage #(
  parameter int DATASIZE = 8
) (
  input  logic                  rclk_i,
  input  logic                  rrst_n_i,
`ifdef RD_FWFT_FLUSH_EN
  input  logic                  flush_i,
`endif
  rd_fwft_stage_if.master       bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATASIZE-1:0] head_q, head_d;
  logic [DATASIZE-1:0] tail_q, tail_d;
  logic                ren;
  logic                push;
  logic                pop;

  always_ff @(posedge rclk_i or negedge rrst_n_i) begin
    if (!rrst_n_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;

    // ren is gated by reset so nothing is requested while the stage is held cleared
    ren  = rrst_n_i & ~bus.fifo_empty_i & (state_q != TWO);
    pop  = (state_q != EMPTY) & bus.dout_ready_i;
`ifdef RD_FWFT_FLUSH_EN
    ren  = ren & ~flush_i;
    pop  = pop & ~flush_i;
`endif
    push = ren;

    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = bus.rdata_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = bus.rdata_i;
        end else if (push) begin
          tail_d  = bus.rdata_i;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

`ifdef RD_FWFT_FLUSH_EN
    if (flush_i) begin
      state_d = EMPTY;
    end
`endif
  end

  assign bus.ren_o        = ren;
  assign bus.dout_o       = head_q;
  assign bus.dout_valid_o = (state_q != EMPTY);
  assign bus.occupancy_o  = state_q;

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Directed bench for rd_fwft_stage: a small read-pointer model feeds words, each
// step checks the stage outputs against hand-computed values.
module tb_rd_fwft_stage;

  logic rclk_i;
  logic rrst_n_i;
`ifdef RD_FWFT_FLUSH_EN
  logic flush_i;
`endif

  rd_fwft_stage_if #(.DATASIZE(8)) bus ();

  rd_fwft_stage #(.DATASIZE(8)) dut (
    .rclk_i   (rclk_i),
    .rrst_n_i (rrst_n_i),
`ifdef RD_FWFT_FLUSH_EN
    .flush_i  (flush_i),
`endif
    .bus      (bus.master)
  );

  initial rclk_i = 1'b0;
  always #5 rclk_i = ~rclk_i;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [0:31];
  int unsigned rptr = 0;
  int unsigned wptr = 0;
  logic        ren_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Read-pointer/empty model: registered empty flag and word at the read address
  task automatic drive_env();
    bus.fifo_empty_i = (rptr >= wptr);
    bus.rdata_i      = mem[rptr % 32];
  endtask

  task automatic tick();
    ren_prev = bus.ren_o;
    @(posedge rclk_i);
    if (ren_prev) rptr++;
    #1;
    drive_env();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    rrst_n_i         = 1'b0;
    bus.dout_ready_i = 1'b0;
`ifdef RD_FWFT_FLUSH_EN
    flush_i = 1'b0;
`endif
    drive_env();
    #2;
    chk("rst_ren",   bus.ren_o,        0);
    chk("rst_valid", bus.dout_valid_o, 0);
    chk("rst_occ",   bus.occupancy_o,  0);
    chk("rst_dout",  bus.dout_o,       0);

    // data available during reset must not raise ren
    wptr = 3;
    drive_env();
    #1;
    chk("rst_ren_gated", bus.ren_o, 0);
    wptr = 0;
    drive_env();
    #1;
    rrst_n_i = 1'b1;
    #1;

    // idle with empty FIFO; ready toggling has no effect
    for (int c = 0; c < 10; c++) begin
      bus.dout_ready_i = c[0];
      tick();
      chk("idle_ren",   bus.ren_o,        0);
      chk("idle_valid", bus.dout_valid_o, 0);
      chk("idle_occ",   bus.occupancy_o,  0);
    end

    // fall-through of 0x11, 0x22, 0x33
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    wptr = 3;
    bus.dout_ready_i = 1'b1;
    drive_env();
    #1;
    chk("ft_ren0",   bus.ren_o,        1);
    chk("ft_valid0", bus.dout_valid_o, 0);
    tick();
    chk("ft_valid1", bus.dout_valid_o, 1);
    chk("ft_dout1",  bus.dout_o,       8'h11);
    tick();
    chk("ft_dout2",  bus.dout_o,       8'h22);
    tick();
    chk("ft_dout3",  bus.dout_o,       8'h33);
    chk("ft_ren3",   bus.ren_o,        0);
    tick();
    chk("ft_drained", bus.dout_valid_o, 0);
    chk("ft_occ",     bus.occupancy_o,  0);

    // backpressure with 5 words available
    mem[3] = 8'h11; mem[4] = 8'h22; mem[5] = 8'h33; mem[6] = 8'h44; mem[7] = 8'h55;
    wptr = 8;
    bus.dout_ready_i = 1'b0;
    drive_env();
    #1;
    tick();
    chk("bp_occ1",  bus.occupancy_o, 1);
    chk("bp_dout1", bus.dout_o,      8'h11);
    tick();
    chk("bp_occ2",  bus.occupancy_o, 2);
    chk("bp_ren",   bus.ren_o,       0);
    chk("bp_dout2", bus.dout_o,      8'h11);
    tick();
    tick();
    chk("bp_hold_dout",  bus.dout_o,       8'h11);
    chk("bp_hold_valid", bus.dout_valid_o, 1);
    chk("bp_hold_occ",   bus.occupancy_o,  2);
    chk("bp_rptr",       rptr,             5);
    bus.dout_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", bus.dout_valid_o, 1);
      chk("bp_order", bus.dout_o,       8'h11 * (k + 1));
      tick();
    end
    chk("bp_drained", bus.dout_valid_o, 0);

    // FIFO goes empty after two reads
    mem[8] = 8'hA1; mem[9] = 8'hA2;
    wptr = 10;
    drive_env();
    #1;
    tick();
    chk("em_dout1", bus.dout_o, 8'hA1);
    chk("em_ren1",  bus.ren_o,  1);
    tick();
    chk("em_empty",  bus.fifo_empty_i, 1);
    chk("em_ren2",   bus.ren_o,        0);
    chk("em_dout2",  bus.dout_o,       8'hA2);
    chk("em_valid2", bus.dout_valid_o, 1);
    tick();
    chk("em_valid3", bus.dout_valid_o, 0);
    tick();
    chk("em_valid4", bus.dout_valid_o, 0);
    chk("em_rptr",   rptr,             10);

    // asynchronous reset while two words are buffered
    mem[10] = 8'hB1; mem[11] = 8'hB2; mem[12] = 8'hB3; mem[13] = 8'hB4;
    wptr = 14;
    bus.dout_ready_i = 1'b0;
    drive_env();
    #1;
    tick();
    tick();
    chk("ar_occ_pre", bus.occupancy_o, 2);
    #2;
    rrst_n_i = 1'b0;
    #1;
    chk("ar_valid", bus.dout_valid_o, 0);
    chk("ar_occ",   bus.occupancy_o,  0);
    chk("ar_dout",  bus.dout_o,       0);
    chk("ar_ren",   bus.ren_o,        0);
    rrst_n_i = 1'b1;
    #1;
    chk("ar_ren_rel", bus.ren_o, 1);
    tick();
    chk("ar_dout1", bus.dout_o, 8'hB3);
    bus.dout_ready_i = 1'b1;
    #1;
    tick();
    chk("ar_dout2", bus.dout_o, 8'hB4);
    tick();
    chk("ar_drained", bus.dout_valid_o, 0);

`ifdef RD_FWFT_FLUSH_EN
    // flush at full occupancy, with ready high to show flush beats pop
    mem[14] = 8'hC1; mem[15] = 8'hC2; mem[16] = 8'hC3; mem[17] = 8'hC4;
    wptr = 16;
    bus.dout_ready_i = 1'b0;
    drive_env();
    #1;
    tick();
    tick();
    chk("fl_occ_pre", bus.occupancy_o, 2);
    wptr = 18;
    drive_env();
    flush_i          = 1'b1;
    bus.dout_ready_i = 1'b1;
    #1;
    chk("fl_ren", bus.ren_o, 0);
    tick();
    flush_i = 1'b0;
    #1;
    chk("fl_occ",   bus.occupancy_o,  0);
    chk("fl_valid", bus.dout_valid_o, 0);
    chk("fl_ren2",  bus.ren_o,        1);
    tick();
    chk("fl_next", bus.dout_o, 8'hC3);
    tick();
    chk("fl_next2", bus.dout_o, 8'hC4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_fwft_stage.md
RD_FWFT_STAGE -- requirements
Module: rd_fwft_stage

Interface
REQ-001 Parameter DATASIZE, default 8: width of the read-data word.
REQ-002 rclk_i  input  1  read-domain clock; all state updates on its rising edge.
REQ-003 rrst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 fifo_empty_i  input  1  registered empty flag from the read-pointer/empty block.
REQ-005 rdata_i  input  DATASIZE  memory word at the current read address; valid in the same cycle ren_o is high.
REQ-006 ren_o  output  1  read enable to the read-pointer/empty block; advances the read address at the next edge.
REQ-007 dout_o  output  DATASIZE  head-of-buffer data presented to the consumer.
REQ-008 dout_valid_o  output  1  dout_o holds an unconsumed word.
REQ-009 dout_ready_i  input  1  consumer accepts dout_o this cycle.
REQ-010 occupancy_o  output  2  words held in the output buffer, 0..2.
REQ-011 flush_i  input  1  synchronous buffer flush; present only when RD_FWFT_FLUSH_EN is defined.

Function
REQ-012 The block SHALL be a first-word-fall-through stage with a 2-entry buffer, head then tail, and states EMPTY, ONE and TWO that track occupancy_o values 0, 1 and 2.
REQ-013 ren_o SHALL equal ~fifo_empty_i AND (occupancy_o < 2); it SHALL NOT depend combinationally on dout_ready_i.
REQ-014 push = ren_o; pop = dout_valid_o AND dout_ready_i; both are evaluated in the same cycle.
REQ-015 On push, rdata_i SHALL be captured at that clock edge: into head in EMPTY, or in ONE when pop is also asserted; into tail in ONE when pop is not asserted.
REQ-016 Transitions: EMPTY+push->ONE; ONE+push&!pop->TWO; ONE+pop&!push->EMPTY; ONE+push&pop->ONE; TWO+pop->ONE with head<=tail; all other cases hold state.
REQ-017 dout_valid_o SHALL be 1 exactly in ONE and TWO, and dout_o SHALL equal head.
REQ-018 Latency: a word read while in EMPTY SHALL appear on dout_o with dout_valid_o=1 one cycle after ren_o is high.
REQ-019 Sustained throughput SHALL be one word per cycle while fifo_empty_i=0 and dout_ready_i=1.
REQ-020 Words SHALL leave in the order they were read; no word is dropped or duplicated.
REQ-021 While dout_valid_o=1 and dout_ready_i=0, dout_o and dout_valid_o SHALL hold stable.
REQ-022 dout_ready_i while dout_valid_o=0 SHALL have no effect.
REQ-023 pop in TWO SHALL NOT coincide with a push, because ren_o=0 in TWO.
REQ-024 When fifo_empty_i rises, ren_o SHALL drop in the same cycle, and buffered words SHALL remain deliverable.

Reset
REQ-025 While rrst_n_i=0: state EMPTY, occupancy_o=0, dout_valid_o=0, dout_o=0, head=0, tail=0, ren_o=0.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered words immediately, without waiting for a clock edge.
REQ-027 After release, the first push SHALL occur no earlier than the first edge at which fifo_empty_i=0.

Configuration
REQ-028 Macro RD_FWFT_FLUSH_EN SHALL control the flush feature.
REQ-029 When RD_FWFT_FLUSH_EN is defined, flush_i=1 SHALL force ren_o=0 in that cycle and move the stage to EMPTY at the next edge, with occupancy_o=0 and dout_valid_o=0.
REQ-030 When RD_FWFT_FLUSH_EN is defined, flush_i SHALL take priority over pop, and no pop SHALL be counted in the flush cycle.
REQ-031 When RD_FWFT_FLUSH_EN is not defined, the flush_i port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset and empty: hold fifo_empty_i=1 for 10 cycles after reset -> ren_o=0, dout_valid_o=0, occupancy_o=0 throughout.
REQ-033 Fall-through: words 0x11, 0x22 and 0x33 available, dout_ready_i=1 -> dout_o reads 0x11, 0x22, 0x33 on consecutive cycles, the first one cycle after ren_o.
REQ-034 Backpressure: dout_ready_i=0 with 5 words available -> occupancy_o reaches 2, ren_o=0, and dout_o holds 0x11 stable; release dout_ready_i -> 0x11..0x55 delivered in order with no gaps.
REQ-035 Empty mid-stream: fifo_empty_i rises after 2 reads -> ren_o=0 in that same cycle, and exactly 2 words are delivered.
REQ-036 Async reset mid-operation: assert rrst_n_i low between edges while occupancy_o=2 -> dout_valid_o=0 and occupancy_o=0 immediately.
REQ-037 Flush (RD_FWFT_FLUSH_EN defined): flush_i=1 at occupancy_o=2 -> occupancy_o=0 next cycle, and the next delivered word is the first memory word after the flush.
